half_adder: RTL and testbench



---
 rtl/half_adder.sv | 66 ++++++
 tb/tb_half_adder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// half_adder: registered, width-parameterised adder primitive for a CGRA tile.
// Computes a + b + (carry_listen & carry_in) and registers the sum and
// carry-out one clock after the operands are sampled. While on_off is low
// the outputs are driven to zero so downstream tiles see a quiet bus.
// Optional build macro HALF_ADDER_SATURATE_EN: an overflowing sum clamps c
// to all-ones (carry_out still reports the overflow).

module half_adder #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             carry_in,
  input  logic             carry_listen,
  input  logic             on_off,
  output logic [width-1:0] c,
  output logic             carry_out,
  output logic             out_valid
);

  logic             cin_eff;
  logic [width:0]   sum;
  logic [width-1:0] c_next;

  // Gate the upstream carry so an unknown carry_in cannot leak through when ignored.
  always_comb begin
    cin_eff = carry_listen & carry_in;
  end

  // Zero-extended width+1 addition; the top bit is the carry out of bit width-1.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin_eff};
  end

`ifdef HALF_ADDER_SATURATE_EN
  // Clamp the low bits to all-ones whenever the addition overflows.
  always_comb begin
    c_next = sum[width] ? {width{1'b1}} : sum[width-1:0];
  end
`else
  // Plain modular wrap: keep only the low width bits.
  always_comb begin
    c_next = sum[width-1:0];
  end
`endif

  // Output registers: load the result while on, drive a quiet zero bus while off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c         <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else if (on_off) begin
      c         <= c_next;
      carry_out <= sum[width];
      out_valid <= 1'b1;
    end else begin
      c         <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed scoreboard bench for half_adder (width = 8).
// Expected results are computed from the stimulus and queued when driven,
// then popped and compared one cycle later after the rising edge.

module tb_half_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] c;
    logic         carry_out;
    logic         out_valid;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         carry_listen;
  logic         on_off;
  logic [W-1:0] c;
  logic         carry_out;
  logic         out_valid;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  half_adder #(.width(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a),
    .b            (b),
    .carry_in     (carry_in),
    .carry_listen (carry_listen),
    .on_off       (on_off),
    .c            (c),
    .carry_out    (carry_out),
    .out_valid    (out_valid)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of one registered result.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic mlisten, input logic mon);
    exp_t        e;
    logic [W:0]  s;
    logic        use_cin;
    e = '0;
    if (mon === 1'b1) begin
      use_cin = (mlisten === 1'b1) && (mcin === 1'b1);
      s = W'(0) + ma;
      s = s + mb + (use_cin ? 1 : 0);
`ifdef HALF_ADDER_SATURATE_EN
      e.c = s[W] ? {W{1'b1}} : s[W-1:0];
`else
      e.c = s[W-1:0];
`endif
      e.carry_out = s[W];
      e.out_valid = 1'b1;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tcin, input logic tlisten, input logic ton);
    a            = ta;
    b            = tb;
    carry_in     = tcin;
    carry_listen = tlisten;
    on_off       = ton;
    sb.push_back(model(ta, tb, tcin, tlisten, ton));
    @(posedge clk);
    #1;
  endtask

  task automatic compareAll(input string tag, input exp_t e);
    vectors++;
    assert (c === e.c) else begin
      miscompares++;
      $error("[TB] FAIL %s c: observed %0d expected %0d", tag, c, e.c);
    end
    assert (carry_out === e.carry_out) else begin
      miscompares++;
      $error("[TB] FAIL %s carry_out: observed %b expected %b", tag, carry_out, e.carry_out);
    end
    assert (out_valid === e.out_valid) else begin
      miscompares++;
      $error("[TB] FAIL %s out_valid: observed %b expected %b", tag, out_valid, e.out_valid);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s scoreboard: observed empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      compareAll(tag, e);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    a            = '0;
    b            = '0;
    carry_in     = 1'b0;
    carry_listen = 1'b0;
    on_off       = 1'b0;

    // Reset held across an edge: everything quiet.
    #7;
    compareAll("reset_hold", exp_t'('0));
    rst_n = 1'b1;
    #1;
    compareAll("reset_release", exp_t'('0));

    // Basic add.
    applyStimulus(8'd5, 8'd10, 1'b0, 1'b0, 1'b1);
    checkOutput("add_5_10");

    // Overflow wrap (or saturate).
    applyStimulus(8'd250, 8'd21, 1'b0, 1'b0, 1'b1);
    checkOutput("overflow_250_21");

    // Unit off: outputs cleared and held while off.
    applyStimulus(8'd250, 8'd21, 1'b0, 1'b0, 1'b0);
    checkOutput("off_1");
    applyStimulus(8'd250, 8'd21, 1'b1, 1'b1, 1'b0);
    checkOutput("off_2");

    // Carry-in handling.
    applyStimulus(8'd255, 8'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("cin_listen");
    applyStimulus(8'd255, 8'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("cin_ignored");
    applyStimulus(8'd255, 8'd0, 1'bx, 1'b0, 1'b1);
    checkOutput("cin_x_ignored");
    applyStimulus(8'd255, 8'd255, 1'b1, 1'b1, 1'b1);
    checkOutput("ones_plus_ones_cin");
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("zero_plus_zero");

    // Back-to-back stream, one result per cycle.
    for (int i = 0; i <= 20; i++) begin
      applyStimulus(W'(i), W'(2 * i), 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("stream_%0d", i));
    end

    // Asynchronous reset between edges while a result is held.
    applyStimulus(8'd5, 8'd10, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_async_reset");
    #3;
    rst_n = 1'b0;
    #1;
    compareAll("async_reset_clear", exp_t'('0));
    #1;
    rst_n = 1'b1;
    #1;
    compareAll("async_reset_released", exp_t'('0));
    applyStimulus(8'd5, 8'd10, 1'b0, 1'b0, 1'b1);
    checkOutput("post_reset_first");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
